// File: rtl/hilo_muldiv_if.sv
// Execute-stage handshake and HI/LO write-back bundle for hilo_muldiv_ctrl.
interface hilo_muldiv_if;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        flush_i;
    logic        stall_o;
    logic        busy_o;
    logic        hi_we_o;
    logic        lo_we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output start_i, op_i, a_i, b_i, flush_i,
        input  stall_o, busy_o, hi_we_o, lo_we_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, flush_i,
        output stall_o, busy_o, hi_we_o, lo_we_o, hi_o, lo_o
    );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO sequencer: fixed-latency multiply, 32-step restoring divide, MTHI/MTLO.
// Optional macro MD_EARLY_OUT_EN: divides with |a| < |b| complete in one cycle.
module hilo_muldiv_ctrl #(
    parameter int unsigned MUL_LAT   = 2,
    parameter int unsigned DIV_ITERS = 32
) (
    input  logic            clk,
    input  logic            rst,
    hilo_muldiv_if.slave    bus
);
    localparam int unsigned MAX_CNT = (MUL_LAT > DIV_ITERS) ? MUL_LAT : DIV_ITERS;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT) + 1;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state, nextState;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        rem, quo, divisor;
    logic               negQ, negR;
    logic               accept, loadMul, loadDiv, loadFixed;
    logic               stall, hiWe, loWe;
    logic [31:0]        hiOut, loOut;

    // Operand preparation shared by the multiply and divide launch paths
    logic        signedDiv, earlyOut;
    logic [31:0] magA, magB;
    logic [63:0] extA, extB, product;
    logic [32:0] shifted, diff;

    assign signedDiv = (bus.op_i == OP_DIV);
    assign magA      = (signedDiv && bus.a_i[31]) ? 32'(-bus.a_i) : bus.a_i;
    assign magB      = (signedDiv && bus.b_i[31]) ? 32'(-bus.b_i) : bus.b_i;
    assign extA      = {{32{(bus.op_i == OP_MULT) & bus.a_i[31]}}, bus.a_i};
    assign extB      = {{32{(bus.op_i == OP_MULT) & bus.b_i[31]}}, bus.b_i};
    assign product   = 64'(extA * extB);
    assign shifted   = {rem, quo[31]};
    assign diff      = shifted - {1'b0, divisor};

`ifdef MD_EARLY_OUT_EN
    assign earlyOut = (magA < magB);
`else
    assign earlyOut = 1'b0;
`endif

    assign accept = bus.start_i && !bus.flush_i && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        stall     = 1'b0;
        hiWe      = 1'b0;
        loWe      = 1'b0;
        hiOut     = 32'h0;
        loOut     = 32'h0;
        loadMul   = 1'b0;
        loadDiv   = 1'b0;
        loadFixed = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (bus.op_i)
                        OP_MULT, OP_MULTU: begin
                            stall     = 1'b1;
                            loadMul   = 1'b1;
                            nextState = MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            stall = 1'b1;
                            if (bus.b_i == 32'h0 || earlyOut) begin
                                loadFixed = 1'b1;
                                nextState = DONE;
                            end else begin
                                loadDiv   = 1'b1;
                                nextState = DIV;
                            end
                        end
                        OP_MTHI: begin
                            hiWe  = 1'b1;
                            hiOut = bus.a_i;
                        end
                        OP_MTLO: begin
                            loWe  = 1'b1;
                            loOut = bus.a_i;
                        end
                        default: ;
                    endcase
                end
            end
            MUL, DIV: begin
                if (bus.flush_i) begin
                    nextState = IDLE;
                end else begin
                    stall = 1'b1;
                    if (cnt == '0) nextState = DONE;
                end
            end
            DONE: begin
                nextState = IDLE;
                if (!bus.flush_i) begin
                    hiWe  = 1'b1;
                    loWe  = 1'b1;
                    hiOut = negR ? 32'(-rem) : rem;
                    loOut = negQ ? 32'(-quo) : quo;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Result/iteration datapath; rem/quo double as HI/LO holding registers for multiply
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            rem     <= 32'h0;
            quo     <= 32'h0;
            divisor <= 32'h0;
            negQ    <= 1'b0;
            negR    <= 1'b0;
        end else if (loadMul) begin
            rem  <= product[63:32];
            quo  <= product[31:0];
            negQ <= 1'b0;
            negR <= 1'b0;
            cnt  <= CNT_W'(MUL_LAT - 1);
        end else if (loadDiv) begin
            rem     <= 32'h0;
            quo     <= magA;
            divisor <= magB;
            negQ    <= signedDiv & (bus.a_i[31] ^ bus.b_i[31]);
            negR    <= signedDiv & bus.a_i[31];
            cnt     <= CNT_W'(DIV_ITERS - 1);
        end else if (loadFixed) begin
            rem  <= bus.a_i;
            quo  <= (bus.b_i == 32'h0) ? 32'hFFFF_FFFF : 32'h0;
            negQ <= 1'b0;
            negR <= 1'b0;
        end else if (state == MUL) begin
            cnt <= cnt - CNT_W'(1);
        end else if (state == DIV) begin
            cnt <= cnt - CNT_W'(1);
            if (!diff[32]) begin
                rem <= diff[31:0];
                quo <= {quo[30:0], 1'b1};
            end else begin
                rem <= shifted[31:0];
                quo <= {quo[30:0], 1'b0};
            end
        end
    end

    assign bus.stall_o = stall;
    assign bus.busy_o  = (state != IDLE);
    assign bus.hi_we_o = hiWe;
    assign bus.lo_we_o = loWe;
    assign bus.hi_o    = hiOut;
    assign bus.lo_o    = loOut;
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl against an arithmetic reference model.
module tb_hilo_muldiv_ctrl;
    localparam int unsigned MUL_LAT = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hilo_muldiv_if bus();

    hilo_muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_ITERS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference: what the HI/LO unit should write, and on which cycle after start
    task automatic refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int lat, output logic [1:0] mask,
                            output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, q, r, ma, mb;
        logic [63:0] p;
        lat = -1; mask = 2'b00; hi = 32'h0; lo = 32'h0;
        case (op)
            3'd0: begin
                p = 64'(longint'($signed(a)) * longint'($signed(b)));
                hi = p[63:32]; lo = p[31:0]; mask = 2'b11; lat = int'(MUL_LAT) + 1;
            end
            3'd1: begin
                p = {32'h0, a} * {32'h0, b};
                hi = p[63:32]; lo = p[31:0]; mask = 2'b11; lat = int'(MUL_LAT) + 1;
            end
            3'd2, 3'd3: begin
                mask = 2'b11;
                if (b == 32'h0) begin
                    hi = a; lo = 32'hFFFF_FFFF; lat = 1;
                end else begin
                    sa = (op == 3'd2) ? longint'($signed(a)) : longint'({32'h0, a});
                    sb = (op == 3'd2) ? longint'($signed(b)) : longint'({32'h0, b});
                    q = sa / sb;
                    r = sa % sb;
                    lo = 32'(q); hi = 32'(r); lat = 33;
                    ma = (sa < 0) ? -sa : sa;
                    mb = (sb < 0) ? -sb : sb;
`ifdef MD_EARLY_OUT_EN
                    if (ma < mb) lat = 1;
`else
                    if (ma < mb) lat = 33;
`endif
                end
            end
            3'd4: begin hi = a; mask = 2'b10; lat = 0; end
            3'd5: begin lo = a; mask = 2'b01; lat = 0; end
            default: ;
        endcase
    endtask

    // Issue one op and observe the write-back; gathers observations only
    task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int stallCnt, output int weCnt, output int leakCnt,
                         output logic [1:0] mask, output logic [31:0] hi, output logic [31:0] lo,
                         output logic busyAfter);
        lat = -1; stallCnt = 0; weCnt = 0; leakCnt = 0; mask = 2'b00;
        hi = 32'h0; lo = 32'h0; busyAfter = 1'b0;
        @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = op; bus.a_i = a; bus.b_i = b;
        for (int k = 0; k < 45; k++) begin
            if (k > 0) begin
                @(negedge clk);
                bus.start_i = 1'b0;
            end
            #1;
            if (bus.stall_o) stallCnt++;
            if (!bus.hi_we_o && bus.hi_o != 32'h0) leakCnt++;
            if (!bus.lo_we_o && bus.lo_o != 32'h0) leakCnt++;
            if (bus.hi_we_o || bus.lo_we_o) begin
                weCnt++;
                if (lat < 0) begin
                    lat = k; mask = {bus.hi_we_o, bus.lo_we_o};
                    hi = bus.hi_o; lo = bus.lo_o;
                end
            end
            if (lat >= 0 && k == lat + 1) begin
                busyAfter = bus.busy_o;
                break;
            end
        end
        if (lat < 0) busyAfter = bus.busy_o;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start_i = 1'b1; bus.op_i = 3'd4; bus.a_i = 32'h5; bus.b_i = 32'h0; bus.flush_i = 1'b0;
        #1;
        checks++;
        if ({bus.stall_o, bus.busy_o, bus.hi_we_o, bus.lo_we_o, bus.hi_o, bus.lo_o} !== 68'h0) begin
            errors++;
            $display("FAIL reset_outputs: got stall=%b busy=%b hwe=%b lwe=%b hi=%h lo=%h, expected all 0",
                     bus.stall_o, bus.busy_o, bus.hi_we_o, bus.lo_we_o, bus.hi_o, bus.lo_o);
        end
        @(negedge clk); @(negedge clk);
        bus.start_i = 1'b0;
        rst = 1'b0;
    endtask

    task automatic checkOp(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int eLat, oLat, oStall, oWe, oLeak, eStall, eWe;
        logic [1:0] eMask, oMask;
        logic [31:0] eHi, eLo, oHi, oLo;
        logic oBusy;
        refModel(op, a, b, eLat, eMask, eHi, eLo);
        runOp(op, a, b, oLat, oStall, oWe, oLeak, oMask, oHi, oLo, oBusy);
        eStall = (eLat > 0) ? eLat : 0;
        eWe = (eMask != 2'b00) ? 1 : 0;
        checks++;
        if (oLat !== eLat || oStall !== eStall || oWe !== eWe) begin
            errors++;
            $display("FAIL %s timing: op=%0d a=%h b=%h got lat=%0d stall=%0d writes=%0d, expected lat=%0d stall=%0d writes=%0d",
                     name, op, a, b, oLat, oStall, oWe, eLat, eStall, eWe);
        end
        checks++;
        if (oMask !== eMask || oHi !== eHi || oLo !== eLo) begin
            errors++;
            $display("FAIL %s result: op=%0d a=%h b=%h got we=%b hi=%h lo=%h, expected we=%b hi=%h lo=%h",
                     name, op, a, b, oMask, oHi, oLo, eMask, eHi, eLo);
        end
        checks++;
        if (oLeak !== 0 || oBusy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: op=%0d got leaks=%0d busy_after=%b, expected 0 and 0", name, op, oLeak, oBusy);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  ops [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd5, 3'd3, 3'd2, 3'd4, 3'd6};
        logic [31:0] as  [10] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100, 32'd5,
                                  32'h1234, 32'd3, 32'h8000_0000, 32'hCAFE_F00D, 32'h77};
        logic [31:0] bs  [10] = '{32'd3, 32'd2, 32'd2, 32'd7, 32'd0,
                                  32'h0, 32'd10, 32'hFFFF_FFFF, 32'h0, 32'd9};
        for (int i = 0; i < 10; i++) checkOp($sformatf("directed%0d", i), ops[i], as[i], bs[i]);
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic [31:0] a, b;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: b = 32'($urandom_range(1, 20));
                2: begin a = 32'($urandom_range(0, 50)); b = $urandom | 32'h100; end
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4: begin a = 32'($signed(-$urandom_range(1, 1000))); b = 32'($urandom_range(1, 40)); end
                default: ;
            endcase
            checkOp($sformatf("random%0d", i), op, a, b);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = 3'd1; bus.a_i = 32'hFFFF_FFFF; bus.b_i = 32'd2;
        for (int k = 1; k <= int'(MUL_LAT) + 2; k++) begin
            @(negedge clk);
            bus.op_i = 3'd4; bus.a_i = 32'hDEAD_0000 + 32'(k);
            #1;
            checks++;
            if (k <= int'(MUL_LAT)) begin
                if (bus.hi_we_o !== 1'b0 || bus.stall_o !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_ignore_start: cycle %0d got hwe=%b stall=%b, expected 0 1", k, bus.hi_we_o, bus.stall_o);
                end
            end else if (k == int'(MUL_LAT) + 1) begin
                if ({bus.hi_we_o, bus.lo_we_o, bus.stall_o} !== 3'b110 || bus.hi_o !== 32'h1 || bus.lo_o !== 32'hFFFF_FFFE) begin
                    errors++;
                    $display("FAIL done_ignore_start: got we=%b%b stall=%b hi=%h lo=%h, expected 11 0 00000001 fffffffe",
                             bus.hi_we_o, bus.lo_we_o, bus.stall_o, bus.hi_o, bus.lo_o);
                end
            end else begin
                if ({bus.hi_we_o, bus.lo_we_o} !== 2'b10 || bus.hi_o !== bus.a_i || bus.busy_o !== 1'b0) begin
                    errors++;
                    $display("FAIL start_after_done: got we=%b%b hi=%h busy=%b, expected 10 %h 0",
                             bus.hi_we_o, bus.lo_we_o, bus.hi_o, bus.busy_o, 32'hDEAD_0000 + 32'(k));
                end
            end
        end
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    task automatic test_flush();
        int writes = 0;
        checkOp("mtlo_before_flush", 3'd5, 32'h1234, 32'h0);
        @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = 3'd2; bus.a_i = 32'hFFFF_FFF9; bus.b_i = 32'd2;
        for (int k = 1; k < 10; k++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
            #1;
            if (bus.hi_we_o || bus.lo_we_o) writes++;
        end
        @(negedge clk);
        bus.flush_i = 1'b1;
        #1;
        checks++;
        if ({bus.stall_o, bus.hi_we_o, bus.lo_we_o} !== 3'b000) begin
            errors++;
            $display("FAIL flush_div_same_cycle: got stall=%b we=%b%b, expected 0 00", bus.stall_o, bus.hi_we_o, bus.lo_we_o);
        end
        @(negedge clk);
        bus.flush_i = 1'b0;
        #1;
        checks++;
        if (bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_div_busy: got busy=%b, expected 0", bus.busy_o);
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); #1;
            if (bus.hi_we_o || bus.lo_we_o) writes++;
        end
        checks++;
        if (writes !== 0) begin
            errors++;
            $display("FAIL flush_div_no_write: got %0d writes, expected 0", writes);
        end
        // Flushed MTHI in IDLE, then flush landing on the DONE cycle of a divide by zero
        @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = 3'd4; bus.a_i = 32'h55; bus.flush_i = 1'b1;
        #1;
        checks++;
        if ({bus.hi_we_o, bus.lo_we_o, bus.hi_o} !== 34'h0) begin
            errors++;
            $display("FAIL flush_mthi: got we=%b%b hi=%h, expected 00 00000000", bus.hi_we_o, bus.lo_we_o, bus.hi_o);
        end
        @(negedge clk);
        bus.flush_i = 1'b0; bus.op_i = 3'd3; bus.a_i = 32'd5; bus.b_i = 32'd0;
        @(negedge clk);
        bus.start_i = 1'b0; bus.flush_i = 1'b1;
        #1;
        checks++;
        if ({bus.hi_we_o, bus.lo_we_o, bus.stall_o} !== 3'b000) begin
            errors++;
            $display("FAIL flush_done: got we=%b%b stall=%b, expected 00 0", bus.hi_we_o, bus.lo_we_o, bus.stall_o);
        end
        @(negedge clk);
        bus.flush_i = 1'b0;
        #1;
        checks++;
        if ({bus.busy_o, bus.hi_we_o, bus.lo_we_o} !== 3'b000) begin
            errors++;
            $display("FAIL flush_done_after: got busy=%b we=%b%b, expected 0 00", bus.busy_o, bus.hi_we_o, bus.lo_we_o);
        end
    endtask

    task automatic test_reset_mid();
        int writes = 0;
        @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = 3'd2; bus.a_i = 32'd1000; bus.b_i = 32'd3;
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.stall_o, bus.busy_o, bus.hi_we_o, bus.lo_we_o, bus.hi_o, bus.lo_o} !== 68'h0) begin
            errors++;
            $display("FAIL reset_mid_div: got stall=%b busy=%b we=%b%b hi=%h lo=%h, expected all 0",
                     bus.stall_o, bus.busy_o, bus.hi_we_o, bus.lo_we_o, bus.hi_o, bus.lo_o);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); #1;
            if (bus.hi_we_o || bus.lo_we_o || bus.busy_o) writes++;
        end
        checks++;
        if (writes !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_write: got %0d active cycles, expected 0", writes);
        end
    endtask

    initial begin
        bus.start_i = 1'b0; bus.op_i = 3'd0; bus.a_i = 32'h0; bus.b_i = 32'h0; bus.flush_i = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
- Multi-cycle sequencer for the execute-stage HI/LO resource.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations from execute and runs a fixed-latency multiply or a 32-iteration restoring divide.
- Holds the pipeline stalled while busy, then issues the HI/LO write pulse.
- Replaces the single-cycle HI/LO path in execute; stall_o feeds the hazard unit.

Parameters:
- MUL_LAT, 2, cycles spent in MUL state (>=1).
- DIV_ITERS, 32, divide iterations. Fixed at 32; other values unsupported.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-high reset
- start_i  input  1  valid HI/LO operation in execute this cycle
- op_i  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others = no-op
- a_i  input  32  rs operand (forwarded)
- b_i  input  32  rt operand (forwarded)
- flush_i  input  1  abort in-flight operation (exception/flush of execute)
- stall_o  output  1  stall F/D/E; combinational
- busy_o  output  1  state != IDLE
- hi_we_o  output  1  one-cycle HI write enable
- lo_we_o  output  1  one-cycle LO write enable
- hi_o  output  32  HI write data
- lo_o  output  32  LO write data

Behaviour:
- Reset: state IDLE, all outputs 0, internal registers cleared. Reset mid-operation aborts with no write.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - start_i sampled only in IDLE; ignored in other states.
  - MTHI: same cycle, hi_we_o=1, hi_o=a_i, no stall, stay IDLE.
  - MTLO: same cycle, lo_we_o=1, lo_o=a_i, no stall, stay IDLE.
  - MULT/MULTU: latch operands, stall_o=1 combinationally, go MUL.
  - DIV/DIVU with b_i!=0: latch operands, stall_o=1, go DIV.
  - DIV/DIVU with b_i==0: stall_o=1, go DONE with hi=a_i, lo=32'hFFFF_FFFF.
- MUL: counter runs MUL_LAT cycles, then DONE. Product is the 64-bit product; signed for MULT, unsigned for MULTU. hi = product[63:32], lo = product[31:0].
- DIV:
  - One quotient bit per cycle, MSB first, restoring algorithm on 32-bit magnitudes.
  - DIVU uses raw operands. DIV uses |a|,|b|.
  - After the 32nd iteration, go DONE.
  - Signed fixup in DONE: quotient negated if sign(a)!=sign(b); remainder takes the sign of a.
  - 32'h8000_0000 / -1: quotient 32'h8000_0000, remainder 0.
  - lo = quotient, hi = remainder.
- DONE: stall_o=0, hi_we_o=lo_we_o=1 with final values for one cycle, then IDLE. A new start_i is not accepted in DONE; the next operation can start the cycle after.
- Latency (start accepted at cycle T):
  - MULT: stall_o high T..T+MUL_LAT, write at T+MUL_LAT+1.
  - DIV: stall_o high T..T+32, write at T+33.
  - Divide by zero: stall T, write at T+1.
- busy_o=1 in MUL/DIV/DONE.
- hi_o/lo_o are 0 whenever no write enable is asserted.
- flush_i:
  - In MUL/DIV/DONE: next state IDLE, no write pulse, stall_o drops the same cycle.
  - In IDLE with start_i: the start is ignored, including MTHI/MTLO.
  - Takes priority over start_i and completion.

Optional Feature:
- Macro MD_EARLY_OUT_EN.
- Defined: DIV/DIVU where magnitude(a) < magnitude(b), or a==0, goes straight IDLE->DONE with quotient 0 and remainder a_i (sign per the signed rule). Stall is 1 cycle, write at T+1.
- Undefined: these cases take the full 32-iteration path with identical results.

Test Plan:
- MULT a=32'hFFFF_FFFE (-2), b=3, MUL_LAT=2: stall_o high for 3 cycles, then hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA, both enables pulse once.
- MULTU a=32'hFFFF_FFFF, b=2: hi=1, lo=32'hFFFF_FFFE.
- DIV a=-7, b=2: stall 33 cycles, then lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1).
- DIVU a=100, b=7: lo=14, hi=2.
- DIV b=0, a=5: write at T+1 with hi=5, lo=32'hFFFF_FFFF.
- MTLO a=32'h1234 with no stall (lo_we_o same cycle). Then start DIV, assert flush_i at cycle T+10: no enable pulse, busy_o=0 next cycle.
- Assert rst at cycle T+5 of a DIV: all outputs 0 immediately, no write.
- With MD_EARLY_OUT_EN defined, DIVU 3/10: write at T+1 with lo=0, hi=3.
